muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl_pkg.sv | 23 ++
 rtl/muldiv_ctrl.sv | 176 +++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes,
// FSM encoding and the default multiplier pipeline depth.
package muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MUL      = 3'd1,
    ST_DIV_REQ  = 3'd2,
    ST_DIV_WAIT = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  localparam int unsigned MUL_LAT_DEF = 2;
  localparam int unsigned CNT_W       = 3;

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequences mult/multu/div/divu through external multiplier and divider IP
// and produces a single HI/LO write per committed instruction.
//
// state       | meaning
// ST_IDLE     | waiting for an accepted start
// ST_MUL      | multiplier pipeline running, counter to product capture
// ST_DIV_REQ  | operands offered to divider, waiting for s_ready
// ST_DIV_WAIT | divider busy; drains even when cancelled
// ST_DONE     | result held, done=1 until EXE leaves (ack) or flush
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        flush,
  input  logic        m1s_ex,
  input  logic        ack,
  output logic        done,
  output logic        busy,
  output logic        hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_signed,
  input  logic [63:0] mul_prod,
  output logic        div_s_valid,
  input  logic        div_s_ready,
  output logic        div_signed,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_dout_valid,
  input  logic [31:0] div_quot,
  input  logic [31:0] div_rem
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cancel_q, cancel_d;
  logic             first_q, first_d;
  logic             gap_q, gap_d;
  logic [31:0]      src1_q, src1_d, src2_q, src2_d;
  logic             mul_signed_q, mul_signed_d, div_signed_q, div_signed_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d, busy_q, busy_d, div_s_valid_q, div_s_valid_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cancel_d     = cancel_q;
    first_d      = 1'b0;
    gap_d        = 1'b0;
    src1_d       = src1_q;
    src2_d       = src2_q;
    mul_signed_d = mul_signed_q;
    div_signed_d = div_signed_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    unique case (state_q)
      ST_IDLE: begin
        // gap_q blocks a still-asserted start from re-issuing the instruction just retired
        if (start && !flush && !m1s_ex && !gap_q) begin
          src1_d       = src1;
          src2_d       = src2;
          mul_signed_d = (op_e'(op) == OP_MULT);
          div_signed_d = (op_e'(op) == OP_DIV);
          if (!op[1]) begin
            state_d = ST_MUL;
            cnt_d   = CNT_W'(MUL_LAT - 1);
          end else begin
            state_d = ST_DIV_REQ;
          end
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          hi_d    = mul_prod[63:32];
          lo_d    = mul_prod[31:0];
          state_d = ST_DONE;
          first_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DIV_REQ: begin
        if (flush) cancel_d = 1'b1;
        if (div_s_ready) state_d = ST_DIV_WAIT;
      end
      ST_DIV_WAIT: begin
        if (div_dout_valid) begin
          if (cancel_q || flush) begin
            state_d  = ST_IDLE;
            cancel_d = 1'b0;
          end else begin
            lo_d    = div_quot;
            hi_d    = div_rem;
            state_d = ST_DONE;
            first_d = 1'b1;
          end
        end else if (flush) begin
          cancel_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (ack) begin
          state_d = ST_IDLE;
          gap_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    done_d        = (state_d == ST_DONE);
    busy_d        = (state_d != ST_IDLE);
    div_s_valid_d = (state_d == ST_DIV_REQ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      cancel_q      <= 1'b0;
      first_q       <= 1'b0;
      gap_q         <= 1'b0;
      src1_q        <= '0;
      src2_q        <= '0;
      mul_signed_q  <= 1'b0;
      div_signed_q  <= 1'b0;
      hi_q          <= '0;
      lo_q          <= '0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      div_s_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cancel_q      <= cancel_d;
      first_q       <= first_d;
      gap_q         <= gap_d;
      src1_q        <= src1_d;
      src2_q        <= src2_d;
      mul_signed_q  <= mul_signed_d;
      div_signed_q  <= div_signed_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      div_s_valid_q <= div_s_valid_d;
    end
  end

  // Exception/flush seen in M1 during the first DONE cycle must still kill the write.
  assign hilo_we      = first_q & ~cancel_q & ~m1s_ex & ~flush;
  assign done         = done_q;
  assign busy         = busy_q;
  assign div_s_valid  = div_s_valid_q;
  assign hi_wdata     = hi_q;
  assign lo_wdata     = lo_q;
  assign mul_a        = src1_q;
  assign mul_b        = src2_q;
  assign mul_signed   = mul_signed_q;
  assign div_dividend = src1_q;
  assign div_divisor  = src2_q;
  assign div_signed   = div_signed_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: HI/LO writes are checked by a queue-based
// scoreboard, control timing by inline checks.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, flush, m1s_ex, ack;
  logic [1:0]  op;
  logic [31:0] src1, src2;
  logic        done, busy, hilo_we, mul_signed, div_s_valid, div_s_ready, div_signed;
  logic [31:0] hi_wdata, lo_wdata, mul_a, mul_b, div_dividend, div_divisor, div_quot, div_rem;
  logic [63:0] mul_prod;
  logic        div_dout_valid;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  muldiv_ctrl #(.MUL_LAT(2)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src1(src1), .src2(src2),
    .flush(flush), .m1s_ex(m1s_ex), .ack(ack), .done(done), .busy(busy),
    .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .mul_a(mul_a), .mul_b(mul_b), .mul_signed(mul_signed), .mul_prod(mul_prod),
    .div_s_valid(div_s_valid), .div_s_ready(div_s_ready), .div_signed(div_signed),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_dout_valid(div_dout_valid), .div_quot(div_quot), .div_rem(div_rem)
  );

  always #5 clk = ~clk;

  // Multiplier IP stand-in: combinational full product of the presented operands.
  always_comb begin
    if (mul_signed)
      mul_prod = $signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b});
    else
      mul_prod = {32'b0, mul_a} * {32'b0, mul_b};
  end

  // Scoreboard monitor: every HI/LO write must match the oldest expected entry.
  always @(negedge clk) begin
    if (hilo_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_hilo_we hi=%h lo=%h required no write", hi_wdata, lo_wdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({hi_wdata, lo_wdata} !== e) begin
          errors++;
          $display("FAIL hilo_data got hi=%h lo=%h required hi=%h lo=%h",
                   hi_wdata, lo_wdata, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int maxc, output int n);
    n = 0;
    while (!done && n < maxc) begin
      step();
      n++;
    end
    if (!done) check("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic retire();
    ack = 1'b1;
    step();
    ack = 1'b0;
    start = 1'b0;
  endtask

  task automatic run_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] prod);
    int n;
    start = 1'b1; op = o; src1 = a; src2 = b;
    exp_q.push_back(prod);
    wait_done(20, n);
    check("mul_latency", 64'(n), 64'd3);
    retire();
  endtask

  task automatic run_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r,
                         input int rdy_dly, input int out_dly);
    int held;
    start = 1'b1; op = o; src1 = a; src2 = b;
    exp_q.push_back({r, q});
    step();
    check("div_operands", {div_dividend, div_divisor}, {a, b});
    check("div_signed", 64'(div_signed), 64'(o == 2'b10));
    held = 0;
    for (int i = 0; i < rdy_dly; i++) begin
      if (div_s_valid) held++;
      step();
    end
    check("div_valid_held", 64'(held + int'(div_s_valid)), 64'(rdy_dly + 1));
    div_s_ready = 1'b1;
    step();
    div_s_ready = 1'b0;
    check("div_valid_drop", 64'(div_s_valid), 64'd0);
    repeat (out_dly - 1) step();
    check("div_wait_nodone", 64'(done), 64'd0);
    div_dout_valid = 1'b1; div_quot = q; div_rem = r;
    step();
    div_dout_valid = 1'b0;
    check("div_done", 64'(done), 64'd1);
    retire();
  endtask

  function automatic logic [63:0] outs_vec();
    return {58'b0, done, busy, hilo_we, div_s_valid, mul_signed, div_signed};
  endfunction

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; op = 2'b00; src1 = '0; src2 = '0;
    flush = 1'b0; m1s_ex = 1'b0; ack = 1'b0;
    div_s_ready = 1'b0; div_dout_valid = 1'b0; div_quot = '0; div_rem = '0;
    step(); step();
    check("reset_ctrl", outs_vec(), 64'd0);
    check("reset_data", {hi_wdata, lo_wdata}, 64'd0);
    reset = 1'b0;
    step();

    // mult 0xFFFFFFFF*2, done on cycle 3, then stale start after ack must not restart
    start = 1'b1; op = 2'b00; src1 = 32'hFFFF_FFFF; src2 = 32'd2;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
    step();
    check("mul_signed", 64'(mul_signed), 64'd1);
    check("mul_operands", {mul_a, mul_b}, 64'hFFFF_FFFF_0000_0002);
    n = 1;
    while (!done && n < 20) begin step(); n++; end
    check("mult_latency", 64'(n), 64'd3);
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    check("no_reissue", 64'(busy), 64'd0);
    start = 1'b0;
    step();

    run_mul(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    step();
    run_mul(2'b00, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
    step();

    // DONE held 4 cycles without ack: one write, no restart
    start = 1'b1; op = 2'b00; src1 = 32'd7; src2 = 32'd6;
    exp_q.push_back(64'h0000_0000_0000_002A);
    wait_done(20, n);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (done && busy) n++;
      step();
    end
    check("done_hold_cycles", 64'(n), 64'd4);
    check("done_still", 64'(done), 64'd1);
    retire();
    step();

    // M1 exception at DONE entry: done but no write
    start = 1'b1; op = 2'b01; src1 = 32'd3; src2 = 32'd3;
    step();
    m1s_ex = 1'b1;
    wait_done(20, n);
    check("m1s_ex_done", 64'(done), 64'd1);
    check("m1s_ex_we", 64'(hilo_we), 64'd0);
    retire();
    m1s_ex = 1'b0;
    step();

    run_div(2'b11, 32'd100, 32'd7, 32'd14, 32'd2, 3, 10);
    step();
    run_div(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 4);
    step();
    run_div(2'b11, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1, 2);
    step();

    // flush in DIV_WAIT: drain, no done, next start only after dout_valid
    start = 1'b1; op = 2'b11; src1 = 32'd9; src2 = 32'd3;
    div_s_ready = 1'b1;
    step(); step();
    div_s_ready = 1'b0;
    flush = 1'b1; start = 1'b0;
    step();
    flush = 1'b0;
    start = 1'b1; op = 2'b01; src1 = 32'd2; src2 = 32'd3;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (busy && !done) n++;
      step();
    end
    check("cancel_waits", 64'(n), 64'd3);
    div_dout_valid = 1'b1; div_quot = 32'd3; div_rem = 32'd0;
    step();
    div_dout_valid = 1'b0;
    check("cancel_drain", {62'b0, done, busy}, 64'd0);
    exp_q.push_back(64'h0000_0000_0000_0006);
    step();
    check("start_after_drain", 64'(busy), 64'd1);
    wait_done(20, n);
    retire();
    step();

    // flush in MUL
    start = 1'b1; op = 2'b00; src1 = 32'd4; src2 = 32'd4;
    step();
    flush = 1'b1; start = 1'b0;
    step();
    flush = 1'b0;
    check("flush_mul", {62'b0, done, busy}, 64'd0);
    step(); step();

    // flush and dout_valid together: result discarded
    start = 1'b1; op = 2'b10; src1 = 32'd8; src2 = 32'd2;
    div_s_ready = 1'b1;
    step(); step();
    div_s_ready = 1'b0; start = 1'b0;
    flush = 1'b1; div_dout_valid = 1'b1; div_quot = 32'd4; div_rem = 32'd0;
    step();
    flush = 1'b0; div_dout_valid = 1'b0;
    check("flush_dout", {62'b0, done, busy}, 64'd0);
    step();

    // reset while in DIV_WAIT
    start = 1'b1; op = 2'b10; src1 = 32'h1234_5678; src2 = 32'd3;
    div_s_ready = 1'b1;
    step(); step();
    div_s_ready = 1'b0; start = 1'b0;
    check("pre_reset_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    step();
    check("reset_div_ctrl", outs_vec(), 64'd0);
    check("reset_div_data", {hi_wdata, lo_wdata}, 64'd0);
    check("reset_div_ops", {mul_a, div_divisor}, 64'd0);
    reset = 1'b0;
    step(); step();

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running required finished");
    $fatal(1);
  end

endmodule
